packet_sorter_iter: RTL and testbench
=====================================

# packet_sorter_iter

Parametrised, iterative successor to the transmitter's packet sorter. It accepts one packet of PACKET_WIDTH symbols through a valid/ready handshake and stable-sorts the symbols in ascending or descending order with a multi-cycle odd-even transposition network. It then presents each sorted symbol with its original index, behind the preamble, to the framer. Unlike the previous sorter, it supports runtime sort direction, output backpressure, early termination on already-sorted data, and reports the number of phases used.

## Interface
- PACKET_WIDTH, 8: symbols per packet; must be ≥2.
- DATA_WIDTH, 8: bits per symbol.
- PREAMBLE_LENGTH, 16: preamble bits appended at the LSB end.
- PREAMBLE, 16'hA5A5: preamble value, PREAMBLE_LENGTH bits.
- INDEX_WIDTH (localparam): $clog2(PACKET_WIDTH).
- PHASE_WIDTH (localparam): $clog2(PACKET_WIDTH+1).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  packet_in and descending are valid.
- in_ready  out  1  block can accept a packet.
- packet_in  in  PACKET_WIDTH*DATA_WIDTH  symbol i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- descending  in  1  sort direction; 0 = ascending. Sampled on accept.
- sorted_packet_out  out  PACKET_WIDTH*(DATA_WIDTH+INDEX_WIDTH)+PREAMBLE_LENGTH  result, in the order {idx[N-1]..idx[0], data[N-1]..data[0], PREAMBLE}.
- out_valid  out  1  sorted_packet_out holds a result.
- out_ready  in  1  consumer accepts the result.
- done  out  1  one-cycle pulse when a result is first presented.
- phases_used  out  PHASE_WIDTH  phases taken by the presented result.

## Operation
- States: IDLE, SORT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: load element i = {packet_in symbol i, index i}; latch descending; clear phase counter and the no-swap history; go to SORT.
- SORT: one phase per clock.
  - Phases alternate, starting with even.
  - Even phase compares pairs (0,1),(2,3),…
  - Odd phase compares pairs (1,2),(3,4),…
  - Unpaired end elements pass through unchanged.
- Swap rule for a pair (lower position a, higher position b):
  - Ascending: swap iff data_a > data_b.
  - Descending: swap iff data_a < data_b.
  - Equal data never swaps. This makes the sort stable: tied symbols keep ascending original index.
- Termination: SORT ends after the phase in which either
  - this phase and the previous phase both made no swaps, or
  - the phase count reaches PACKET_WIDTH.
- On termination:
  - Register sorted_packet_out and phases_used.
  - Set out_valid; pulse done; go to HOLD.
- HOLD:
  - sorted_packet_out and phases_used stay stable while out_valid=1.
  - in_ready=0; in_valid is ignored.
  - When out_valid && out_ready, clear out_valid on the next edge and return to IDLE. The output data keeps its last value.
- Position 0 of the result holds the smallest symbol (ascending) or the largest symbol (descending).
- Comparisons are unsigned, DATA_WIDTH bits wide.
- Reset, asserted at any time including mid-SORT or in HOLD:
  - Go to IDLE immediately.
  - in_ready=1 once reset deasserts.
  - out_valid=0, done=0, sorted_packet_out=0, phases_used=0. All internal element registers are cleared.

## Timing
- Accept edge t: the edge where in_valid && in_ready.
- Phase k (k=1..P) is applied at edge t+k.
- out_valid, done, sorted_packet_out and phases_used=P update at edge t+P+1.
- Latency is P+1 cycles:
  - best case P=2 (3 cycles);
  - worst case P=PACKET_WIDTH (PACKET_WIDTH+1 cycles).
- done is high for exactly one cycle per result, regardless of out_ready.
- If out_ready is already high when out_valid rises, the handshake completes in that cycle and in_ready returns one cycle later.
- Throughput is one packet per P+3 cycles at best.
- in_ready is low for the whole of SORT and HOLD; no input buffering.

## Test plan
- Reverse order: N=4, DW=8, symbols 0..3 = 40,30,20,10 (hex), ascending, out_ready=1.
  - Required: data 10,20,30,40; idx 3,2,1,0; phases_used=4; out_valid at t+5; done 1 cycle.
- Pre-sorted: symbols 01,02,03,04, ascending.
  - Required: phases_used=2; out_valid at t+3; idx 0,1,2,3.
- Ties and stability: symbols 55,11,55,11.
  - Ascending required: data 11,11,55,55; idx 1,3,0,2.
  - Descending required: data 55,55,11,11; idx 0,2,1,3.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with a new packet during that time.
  - Required: output stable; in_ready=0; new packet ignored; done single pulse.
  - On out_ready=1: out_valid falls next edge, in_ready rises.
- Reset mid-SORT: assert reset at t+2 of the reverse-order packet.
  - Required: all outputs 0 and in_ready=1 after release; then a second packet 03,01,02,00 sorts to 00,01,02,03 with idx 3,1,2,0.
- Parameter sweep: N=5 and N=8 with random data, both directions, 200 packets each.
  - Required: every result matches a stable-sort reference model; phases_used ≤ N; PREAMBLE present in the LSBs.

Source files
------------

// File: rtl/packet_sorter_iter.sv
// Iterative stable packet sorter: odd-even transposition network, one phase per clock,
// with early exit on two consecutive swap-free phases and a valid/ready result hand-off.
module packet_sorter_iter #(
    parameter int PACKET_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PREAMBLE_LENGTH = 16,
    parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE = 16'hA5A5,
    localparam int INDEX_WIDTH = $clog2(PACKET_WIDTH),
    localparam int PHASE_WIDTH = $clog2(PACKET_WIDTH + 1),
    localparam int OUT_WIDTH = PACKET_WIDTH * (DATA_WIDTH + INDEX_WIDTH) + PREAMBLE_LENGTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PACKET_WIDTH*DATA_WIDTH-1:0] packet_in,
    input  logic                               descending,
    output logic [OUT_WIDTH-1:0]               sorted_packet_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               done,
    output logic [PHASE_WIDTH-1:0]             phases_used
);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0]  data_reg [PACKET_WIDTH];
    logic [INDEX_WIDTH-1:0] idx_reg  [PACKET_WIDTH];
    logic [DATA_WIDTH-1:0]  next_data [PACKET_WIDTH];
    logic [INDEX_WIDTH-1:0] next_idx  [PACKET_WIDTH];
    logic [PHASE_WIDTH-1:0] phase_cnt;
    logic [PHASE_WIDTH-1:0] next_cnt;
    logic                   desc_reg;
    logic                   prev_quiet;
    logic                   term_pending;
    logic                   any_swap;
    logic                   phase_odd;
    logic                   accept;
    logic                   finish;
    logic                   hand_off;
    logic [OUT_WIDTH-1:0]   result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // term_pending is raised on the edge that applies the final phase, so the
    // following SORT cycle only publishes the result.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        hand_off = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SORT;
                end
            end
            SORT: begin
                if (term_pending) begin
                    finish  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    hand_off = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign phase_odd = phase_cnt[0];
    assign next_cnt  = phase_cnt + PHASE_WIDTH'(1);

    // Pairs in one phase are disjoint, so every comparator reads the registered values.
    always_comb begin
        next_data = data_reg;
        next_idx  = idx_reg;
        any_swap  = 1'b0;
        for (int a = 0; a < PACKET_WIDTH - 1; a++) begin
            if (a[0] == phase_odd) begin
                if (desc_reg ? (data_reg[a] < data_reg[a+1]) : (data_reg[a] > data_reg[a+1])) begin
                    next_data[a]   = data_reg[a+1];
                    next_data[a+1] = data_reg[a];
                    next_idx[a]    = idx_reg[a+1];
                    next_idx[a+1]  = idx_reg[a];
                    any_swap       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        result = '0;
        result[PREAMBLE_LENGTH-1:0] = PREAMBLE;
        for (int i = 0; i < PACKET_WIDTH; i++) begin
            result[PREAMBLE_LENGTH + i*DATA_WIDTH +: DATA_WIDTH] = data_reg[i];
            result[PREAMBLE_LENGTH + PACKET_WIDTH*DATA_WIDTH + i*INDEX_WIDTH +: INDEX_WIDTH] = idx_reg[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PACKET_WIDTH; i++) begin
                data_reg[i] <= '0;
                idx_reg[i]  <= '0;
            end
            phase_cnt         <= '0;
            desc_reg          <= 1'b0;
            prev_quiet        <= 1'b0;
            term_pending      <= 1'b0;
            sorted_packet_out <= '0;
            phases_used       <= '0;
            out_valid         <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                for (int i = 0; i < PACKET_WIDTH; i++) begin
                    data_reg[i] <= packet_in[i*DATA_WIDTH +: DATA_WIDTH];
                    idx_reg[i]  <= INDEX_WIDTH'(i);
                end
                desc_reg     <= descending;
                phase_cnt    <= '0;
                prev_quiet   <= 1'b0;
                term_pending <= 1'b0;
            end else if (state_q == SORT && !term_pending) begin
                data_reg     <= next_data;
                idx_reg      <= next_idx;
                phase_cnt    <= next_cnt;
                prev_quiet   <= !any_swap;
                term_pending <= (!any_swap && prev_quiet) || (next_cnt == PHASE_WIDTH'(PACKET_WIDTH));
            end else if (finish) begin
                sorted_packet_out <= result;
                phases_used       <= phase_cnt;
                out_valid         <= 1'b1;
                done              <= 1'b1;
            end else if (hand_off) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_sorter_iter.sv
// Bench for packet_sorter_iter: three instances (N=4,5,8) checked every cycle against a
// selection-sort/phase-count model, plus directed literal cases on the N=4 instance.
module tb_packet_sorter_iter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] in_valid = '0;
    logic [2:0] desc = '0;
    logic [2:0] out_ready = 3'b111;
    logic [7:0] i_sym [3][8];

    wire [2:0]  in_ready_w;
    wire [2:0]  out_valid_w;
    wire [2:0]  done_w;
    wire [7:0]  o_data [3][8];
    wire [2:0]  o_idx  [3][8];
    wire [15:0] o_pre  [3];
    wire [3:0]  o_ph   [3];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] m_data [3][8];
    logic [2:0] m_idx  [3][8];
    logic [15:0] m_pre [3];
    int         m_ph   [3];
    logic [7:0] p_data [3][8];
    logic [2:0] p_idx  [3][8];
    int         p_ph   [3];
    bit         m_busy [3];
    int         m_rise [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int N  = (g == 0) ? 4 : ((g == 1) ? 5 : 8);
        localparam int IW = $clog2(N);
        localparam int PH = $clog2(N + 1);
        localparam int OW = N * (8 + IW) + 16;
        logic [N*8-1:0] pkt;
        logic [OW-1:0]  sorted;
        logic [PH-1:0]  ph;
        logic           irdy;
        logic           ovld;
        logic           dn;

        packet_sorter_iter #(.PACKET_WIDTH(N), .DATA_WIDTH(8), .PREAMBLE_LENGTH(16), .PREAMBLE(16'hA5A5)) dut (
            .clk(clk),
            .reset(reset),
            .in_valid(in_valid[g]),
            .in_ready(irdy),
            .packet_in(pkt),
            .descending(desc[g]),
            .sorted_packet_out(sorted),
            .out_valid(ovld),
            .out_ready(out_ready[g]),
            .done(dn),
            .phases_used(ph)
        );

        assign in_ready_w[g]  = irdy;
        assign out_valid_w[g] = ovld;
        assign done_w[g]      = dn;
        assign o_pre[g]       = sorted[15:0];
        assign o_ph[g]        = 4'(ph);

        for (genvar k = 0; k < 8; k++) begin : sym
            if (k < N) begin : used
                assign pkt[k*8 +: 8]  = i_sym[g][k];
                assign o_data[g][k]   = sorted[16 + k*8 +: 8];
                assign o_idx[g][k]    = 3'(sorted[16 + N*8 + k*IW +: IW]);
            end else begin : unused
                assign o_data[g][k] = 8'd0;
                assign o_idx[g][k]  = 3'd0;
            end
        end
    end

    function automatic int nof(input int u);
        return (u == 0) ? 4 : ((u == 1) ? 5 : 8);
    endfunction

    // Result = stable selection sort; phase count = replay of the transposition rules on plain arrays.
    function automatic void model(input int n, input logic [7:0] s[8], input bit d,
                                  output logic [7:0] rd[8], output logic [2:0] ri[8], output int p);
        bit         taken [8];
        logic [7:0] w [8];
        logic [7:0] t;
        int         best;
        bit         swapped;
        bit         quiet_prev;
        for (int k = 0; k < 8; k++) begin
            rd[k] = 8'd0;
            ri[k] = 3'd0;
            taken[k] = 1'b0;
            w[k] = s[k];
        end
        for (int pos = 0; pos < n; pos++) begin
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!taken[j]) begin
                    if (best < 0) best = j;
                    else if (d ? (s[j] > s[best]) : (s[j] < s[best])) best = j;
                end
            end
            taken[best] = 1'b1;
            rd[pos] = s[best];
            ri[pos] = 3'(best);
        end
        quiet_prev = 1'b0;
        p = n;
        for (int ph = 1; ph <= n; ph++) begin
            swapped = 1'b0;
            for (int a = (ph - 1) % 2; a + 1 < n; a += 2) begin
                if (d ? (w[a] < w[a+1]) : (w[a] > w[a+1])) begin
                    t = w[a];
                    w[a] = w[a+1];
                    w[a+1] = t;
                    swapped = 1'b1;
                end
            end
            if ((!swapped && quiet_prev) || ph == n) begin
                p = ph;
                break;
            end
            quiet_prev = !swapped;
        end
    endfunction

    task automatic checkOutput(input string name, input int u, input longint actual, input longint required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s (inst %0d) at cycle %0d: got 0x%0h, required 0x%0h", name, u, cyc, actual, required);
        end
    endtask

    task automatic checkFields(input int u);
        for (int k = 0; k < nof(u); k++) begin
            checkOutput($sformatf("data[%0d]", k), u, longint'(o_data[u][k]), longint'(m_data[u][k]));
            checkOutput($sformatf("idx[%0d]", k), u, longint'(o_idx[u][k]), longint'(m_idx[u][k]));
        end
        checkOutput("preamble", u, longint'(o_pre[u]), longint'(m_pre[u]));
        checkOutput("phases_used", u, longint'(o_ph[u]), longint'(m_ph[u]));
    endtask

    // Single compare process: tracks each instance's expected hand-shake timeline and output contents.
    always @(negedge clk) begin
        logic [7:0] s [8];
        logic [7:0] rd [8];
        logic [2:0] ri [8];
        int p;
        cyc++;
        for (int u = 0; u < 3; u++) begin
            if (reset) begin
                m_busy[u] = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    m_data[u][k] = 8'd0;
                    m_idx[u][k] = 3'd0;
                end
                m_pre[u] = 16'd0;
                m_ph[u] = 0;
                checkOutput("reset_out_valid", u, longint'(out_valid_w[u]), 0);
                checkOutput("reset_done", u, longint'(done_w[u]), 0);
                checkFields(u);
            end else begin
                checkOutput("in_ready", u, longint'(in_ready_w[u]), longint'(!m_busy[u]));
                if (m_busy[u] && cyc < m_rise[u]) begin
                    checkOutput("out_valid_sorting", u, longint'(out_valid_w[u]), 0);
                    checkOutput("done_sorting", u, longint'(done_w[u]), 0);
                end else if (m_busy[u] && cyc == m_rise[u]) begin
                    for (int k = 0; k < 8; k++) begin
                        m_data[u][k] = p_data[u][k];
                        m_idx[u][k] = p_idx[u][k];
                    end
                    m_ph[u] = p_ph[u];
                    m_pre[u] = 16'hA5A5;
                    checkOutput("out_valid_rise", u, longint'(out_valid_w[u]), 1);
                    checkOutput("done_pulse", u, longint'(done_w[u]), 1);
                    checkOutput("phases_le_n", u, longint'(o_ph[u] <= 4'(nof(u))), 1);
                end else if (m_busy[u]) begin
                    checkOutput("out_valid_hold", u, longint'(out_valid_w[u]), 1);
                    checkOutput("done_after_pulse", u, longint'(done_w[u]), 0);
                end else begin
                    checkOutput("out_valid_idle", u, longint'(out_valid_w[u]), 0);
                    checkOutput("done_idle", u, longint'(done_w[u]), 0);
                end
                checkFields(u);
                if (m_busy[u] && cyc >= m_rise[u] && out_ready[u]) begin
                    m_busy[u] = 1'b0;
                end else if (!m_busy[u] && in_valid[u]) begin
                    for (int k = 0; k < 8; k++) s[k] = i_sym[u][k];
                    model(nof(u), s, desc[u], rd, ri, p);
                    for (int k = 0; k < 8; k++) begin
                        p_data[u][k] = rd[k];
                        p_idx[u][k] = ri[k];
                    end
                    p_ph[u] = p;
                    m_busy[u] = 1'b1;
                    m_rise[u] = cyc + p + 2;
                end
            end
        end
    end

    task automatic applyStimulus(input int u, input logic [7:0] s[8], input bit d);
        int guard = 0;
        while (!in_ready_w[u] && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("in_ready_wait", u, longint'(in_ready_w[u]), 1);
        for (int k = 0; k < 8; k++) i_sym[u][k] = s[k];
        desc[u] = d;
        in_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic waitResult(input int u, output int lat);
        lat = 0;
        while (!out_valid_w[u] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("result_arrived", u, longint'(out_valid_w[u]), 1);
    endtask

    task automatic checkLiteral(input string tag, input logic [7:0] ed[4], input logic [2:0] ei[4], input int ph);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_data[%0d]", tag, k), 0, longint'(o_data[0][k]), longint'(ed[k]));
            checkOutput($sformatf("%s_idx[%0d]", tag, k), 0, longint'(o_idx[0][k]), longint'(ei[k]));
        end
        checkOutput({tag, "_phases"}, 0, longint'(o_ph[0]), longint'(ph));
        checkOutput({tag, "_preamble"}, 0, longint'(o_pre[0]), 64'hA5A5);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] sv [8];
        logic [7:0] rd [8];
        logic [2:0] ri [8];
        logic [7:0] ed [4];
        logic [2:0] ei [4];
        int p;
        int lat;
        int mode;
        int cnt;

        for (int u = 0; u < 3; u++)
            for (int k = 0; k < 8; k++) i_sym[u][k] = 8'd0;

        sv = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        model(4, sv, 1'b0, rd, ri, p);
        checkOutput("model_rev_phases", 0, p, 4);
        checkOutput("model_rev_idx0", 0, longint'(ri[0]), 3);
        sv = '{8'h55, 8'h11, 8'h55, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
        model(4, sv, 1'b1, rd, ri, p);
        checkOutput("model_tie_desc_idx1", 0, longint'(ri[1]), 2);
        checkOutput("model_tie_desc_data3", 0, longint'(rd[3]), 8'h11);
        sv = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        model(4, sv, 1'b0, rd, ri, p);
        checkOutput("model_presorted_phases", 0, p, 2);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reverse order, ascending");
        sv = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, sv, 1'b0);
        waitResult(0, lat);
        checkOutput("rev_latency", 0, lat, 5);
        checkOutput("rev_done", 0, longint'(done_w[0]), 1);
        ed = '{8'h10, 8'h20, 8'h30, 8'h40};
        ei = '{3'd3, 3'd2, 3'd1, 3'd0};
        checkLiteral("rev", ed, ei, 4);
        @(posedge clk);
        #1;
        checkOutput("rev_done_fall", 0, longint'(done_w[0]), 0);
        checkOutput("rev_valid_fall", 0, longint'(out_valid_w[0]), 0);
        checkOutput("rev_ready_back", 0, longint'(in_ready_w[0]), 1);

        $display("[TB] pre-sorted packet");
        sv = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, sv, 1'b0);
        waitResult(0, lat);
        checkOutput("presorted_latency", 0, lat, 3);
        ed = '{8'h01, 8'h02, 8'h03, 8'h04};
        ei = '{3'd0, 3'd1, 3'd2, 3'd3};
        checkLiteral("presorted", ed, ei, 2);
        @(posedge clk);
        #1;

        $display("[TB] ties, both directions");
        sv = '{8'h55, 8'h11, 8'h55, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, sv, 1'b0);
        waitResult(0, lat);
        ed = '{8'h11, 8'h11, 8'h55, 8'h55};
        ei = '{3'd1, 3'd3, 3'd0, 3'd2};
        checkLiteral("tie_asc", ed, ei, 4);
        @(posedge clk);
        #1;
        applyStimulus(0, sv, 1'b1);
        waitResult(0, lat);
        ed = '{8'h55, 8'h55, 8'h11, 8'h11};
        ei = '{3'd0, 3'd2, 3'd1, 3'd3};
        checkLiteral("tie_desc", ed, ei, 4);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        out_ready[0] = 1'b0;
        sv = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, sv, 1'b0);
        waitResult(0, lat);
        checkOutput("bp_done", 0, longint'(done_w[0]), 1);
        ed = '{8'h10, 8'h20, 8'h30, 8'h40};
        ei = '{3'd3, 3'd2, 3'd1, 3'd0};
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                i_sym[0][0] = 8'h01;
                i_sym[0][1] = 8'h02;
                i_sym[0][2] = 8'h03;
                i_sym[0][3] = 8'h04;
                in_valid[0] = 1'b1;
            end
            if (c == 4) in_valid[0] = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("bp_valid_held", 0, longint'(out_valid_w[0]), 1);
            checkOutput("bp_done_low", 0, longint'(done_w[0]), 0);
            checkOutput("bp_in_ready_low", 0, longint'(in_ready_w[0]), 0);
        end
        checkLiteral("bp_stable", ed, ei, 4);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_valid_fall", 0, longint'(out_valid_w[0]), 0);
        checkOutput("bp_in_ready_rise", 0, longint'(in_ready_w[0]), 1);
        checkLiteral("bp_kept", ed, ei, 4);

        $display("[TB] reset during sort");
        applyStimulus(0, sv, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_valid", 0, longint'(out_valid_w[0]), 0);
        checkOutput("rst_done", 0, longint'(done_w[0]), 0);
        checkOutput("rst_in_ready", 0, longint'(in_ready_w[0]), 1);
        checkOutput("rst_phases", 0, longint'(o_ph[0]), 0);
        checkOutput("rst_preamble", 0, longint'(o_pre[0]), 0);
        checkOutput("rst_data0", 0, longint'(o_data[0][0]), 0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("rst_no_stale_result", 0, longint'(out_valid_w[0]), 0);
        sv = '{8'h03, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, sv, 1'b0);
        waitResult(0, lat);
        ed = '{8'h00, 8'h01, 8'h02, 8'h03};
        ei = '{3'd3, 3'd1, 3'd2, 3'd0};
        checkLiteral("post_rst", ed, ei, 4);
        @(posedge clk);
        #1;

        $display("[TB] randomized sweep");
        for (int u = 0; u < 3; u++) begin
            cnt = (u == 0) ? 50 : 200;
            for (int n = 0; n < cnt; n++) begin
                mode = $urandom_range(0, 3);
                for (int k = 0; k < 8; k++) begin
                    if (k >= nof(u)) sv[k] = 8'h00;
                    else if (mode == 0) sv[k] = 8'($urandom_range(0, 3));
                    else if (mode == 1) sv[k] = 8'(k * 20);
                    else if (mode == 2) sv[k] = 8'((nof(u) - k) * 20);
                    else sv[k] = 8'($urandom_range(0, 255));
                end
                out_ready[u] = 1'($urandom_range(0, 1));
                applyStimulus(u, sv, 1'($urandom_range(0, 1)));
                waitResult(u, lat);
                if (!out_ready[u]) begin
                    repeat ($urandom_range(1, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    out_ready[u] = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
